// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the neuron MAC sequencer: default datapath widths
// (common with the DSP slice wrapper and the activation stage) and the
// sequencer state encoding.
package mac_sequencer_pkg;

    // Default operand and accumulator widths of the DSP slice.
    localparam int DEF_A_W         = 18;
    localparam int DEF_B_W         = 18;
    localparam int DEF_ACC_W       = 48;
    localparam int DEF_N_TERMS     = 16;
    localparam int DEF_MAC_LATENCY = 1;

    // State encoding. IDLE must stay at zero so a reset state reads as 0.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mac_sequencer.sv
// Sequencer for one neuron dot product on an external multiply-accumulate
// slice (mac_op = a*b + c). A bias seeds the accumulator, then N_TERMS
// operand pairs are issued one per pass; each slice result is fed back as
// the next c operand. The final sum is offered on a valid/ack port.
//
// Handshakes: an operand pair transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in LOAD and depends on state
// alone. The result is offered while res_valid is high and is retired on the
// edge where res_ack is high; result stays stable until then. start is only
// looked at in IDLE. Reset is synchronous and overrides everything.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int A_W         = DEF_A_W,
    parameter int B_W         = DEF_B_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int N_TERMS     = DEF_N_TERMS,
    parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic [A_W-1:0]   mac_a,
    output logic [B_W-1:0]   mac_b,
    output logic [ACC_W-1:0] mac_c,
    input  logic [ACC_W-1:0] mac_op,
    output logic             res_valid,
    output logic [ACC_W-1:0] result,
    input  logic             res_ack,
    output logic [1:0]       dbg_state_o
);

    // Term counter only ever needs to reach N_TERMS-1; wait counter holds
    // MAC_LATENCY and needs at least one bit even for a combinational slice.
    localparam int CNT_W  = $clog2(N_TERMS) + 1;
    localparam int WAIT_W = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_TERMS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MAC_LATENCY);

    state_e              state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic [A_W-1:0]      mac_a_q;
    logic [B_W-1:0]      mac_b_q;
    logic [ACC_W-1:0]    mac_c_q;
    logic [ACC_W-1:0]    result_q;

    assign cnt_d  = cnt_q + CNT_W'(1);
    assign wait_d = wait_q - WAIT_W'(1);

    // Sequencer FSM: capture bias, issue each pair, wait out the slice
    // latency, fold mac_op back into the accumulator, then hold the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            mac_a_q  <= '0;
            mac_b_q  <= '0;
            mac_c_q  <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= bias;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        mac_a_q <= in_a;
                        mac_b_q <= in_b;
                        mac_c_q <= acc_q;
                        wait_q  <= WAIT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // mac_op is valid on the (MAC_LATENCY+1)-th edge after
                    // the handshake, i.e. once the wait counter has drained.
                    if (wait_q == '0) begin
                        acc_q <= mac_op;
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_LAST) begin
                            result_q <= mac_op;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_DONE: begin
                    if (res_ack) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register.
    assign busy        = (state_q != S_IDLE);
    assign in_ready    = (state_q == S_LOAD);
    assign res_valid   = (state_q == S_DONE);
    assign mac_a       = mac_a_q;
    assign mac_b       = mac_b_q;
    assign mac_c       = mac_c_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer. Three sequencers with different term counts and
// slice latencies are each attached to a behavioural a*b+c slice. A simple
// reference model (signed dot product modulo 2^48) predicts every mac_c
// operand and the final result.
module tb_mac_sequencer;

    localparam int NI = 3;
    localparam int NT [NI] = '{3, 2, 1};
    localparam int LT [NI] = '{1, 3, 0};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        start     [NI];
    logic [47:0] bias_v    [NI];
    logic        busy      [NI];
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [17:0] in_a      [NI];
    logic [17:0] in_b      [NI];
    logic [17:0] mac_a     [NI];
    logic [17:0] mac_b     [NI];
    logic [47:0] mac_c     [NI];
    logic [47:0] mac_op    [NI];
    logic        res_valid [NI];
    logic [47:0] result    [NI];
    logic        res_ack   [NI];
    logic [1:0]  dbg       [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mac_sequencer #(
            .A_W(18), .B_W(18), .ACC_W(48),
            .N_TERMS(NT[g]), .MAC_LATENCY(LT[g])
        ) u_dut (
            .clock(clock), .reset(reset), .start(start[g]), .bias(bias_v[g]),
            .busy(busy[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_a(in_a[g]), .in_b(in_b[g]), .mac_a(mac_a[g]), .mac_b(mac_b[g]),
            .mac_c(mac_c[g]), .mac_op(mac_op[g]), .res_valid(res_valid[g]),
            .result(result[g]), .res_ack(res_ack[g]), .dbg_state_o(dbg[g])
        );

        logic signed [47:0] prod;
        assign prod = $signed(mac_a[g]) * $signed(mac_b[g]) + $signed(mac_c[g]);
        if (LT[g] == 0) begin : g_comb
            assign mac_op[g] = prod;
        end else begin : g_pipe
            logic [47:0] pipe [LT[g]];
            always @(posedge clock) begin
                pipe[0] <= prod;
                for (int i = 1; i < LT[g]; i++) pipe[i] <= pipe[i-1];
            end
            assign mac_op[g] = pipe[LT[g]-1];
        end
    end

    // ---------------- scoreboard state ----------------
    int nvec = 0;
    int nerr = 0;
    logic signed [17:0] pa [16];
    logic signed [17:0] pb [16];
    logic [47:0] exp_q [$];

    // ---------------- driver: one full dot product ----------------
    // gap: idle LOAD cycles before each pair (0 = in_valid held high)
    // junk: drive in_valid with garbage while the sequencer is in WAIT
    // hold: cycles in DONE before res_ack, with start/in_valid pulsed
    // abort_k: assert reset in WAIT of that term (-1 = never)
    task automatic run_dot(input int id, input logic [47:0] b0, input int n,
                           input int gap, input bit junk, input int hold,
                           input int abort_k, input string tn);
        logic [47:0] acc_m;
        logic [47:0] exp_c;
        logic [47:0] exp_res;
        longint      prod;
        int          hs;
        int          hs_prev;
        int          wcnt;
        exp_q.delete();
        acc_m = b0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(acc_m);
            prod  = longint'(pa[k]) * longint'(pb[k]);
            acc_m = acc_m + prod[47:0];
        end
        exp_res = acc_m;
        hs_prev = 0;

        @(negedge clock);
        start[id] = 1'b1; bias_v[id] = b0; in_valid[id] = 1'b0;
        @(negedge clock);
        start[id] = 1'b0; bias_v[id] = {$urandom, $urandom};
        nvec++;
        if ({busy[id], in_ready[id]} !== 2'b11)
            $display("FAIL %s start: busy/in_ready got %b%b exp 11", tn, busy[id], in_ready[id]);

        for (int k = 0; k < n; k++) begin
            if (k == 0 || gap > 0) begin
                for (int g2 = 0; g2 < gap; g2++) begin
                    nvec++;
                    if ({in_ready[id], res_valid[id]} !== 2'b10) begin
                        nerr++;
                        $display("FAIL %s stall%0d: in_ready/res_valid got %b%b exp 10", tn, k, in_ready[id], res_valid[id]);
                    end
                    @(negedge clock);
                end
                in_a[id] = pa[k]; in_b[id] = pb[k]; in_valid[id] = 1'b1;
            end
            @(posedge clock);
            #1;
            hs = cyc;
            if (k > 0 && gap == 0) begin
                nvec++;
                if (hs - hs_prev != LT[id] + 2) begin
                    nerr++;
                    $display("FAIL %s spacing%0d: got %0d exp %0d", tn, k, hs - hs_prev, LT[id] + 2);
                end
            end
            hs_prev = hs;
            if (gap == 0 && k < n - 1) begin
                in_a[id] = pa[k+1]; in_b[id] = pb[k+1]; in_valid[id] = 1'b1;
            end else if (junk) begin
                in_a[id] = 18'($urandom); in_b[id] = 18'($urandom); in_valid[id] = 1'b1;
            end else begin
                in_valid[id] = 1'b0;
            end
            exp_c = exp_q.pop_front();
            wcnt = 0;
            @(negedge clock);
            if (k == abort_k) begin
                reset = 1'b1; in_valid[id] = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                nvec++;
                if ({busy[id], in_ready[id], res_valid[id], dbg[id], mac_a[id], mac_b[id], mac_c[id], result[id]} !== '0) begin
                    nerr++;
                    $display("FAIL %s reset_outputs: got b%b r%b v%b s%0d a%h b%h c%h res%h exp all 0", tn,
                             busy[id], in_ready[id], res_valid[id], dbg[id], mac_a[id], mac_b[id], mac_c[id], result[id]);
                end
                for (int j = 0; j < 6; j++) begin
                    @(negedge clock);
                    nvec++;
                    if ({busy[id], res_valid[id]} !== 2'b00) begin
                        nerr++;
                        $display("FAIL %s post_reset%0d: busy/res_valid got %b%b exp 00", tn, j, busy[id], res_valid[id]);
                    end
                end
                return;
            end
            while (!in_ready[id] && !res_valid[id] && wcnt < 20) begin
                nvec++;
                if ({mac_a[id], mac_b[id], mac_c[id]} !== {pa[k], pb[k], exp_c}) begin
                    nerr++;
                    $display("FAIL %s mac_abc%0d: got %h/%h/%h exp %h/%h/%h", tn, k,
                             mac_a[id], mac_b[id], mac_c[id], pa[k], pb[k], exp_c);
                end
                wcnt++;
                @(negedge clock);
            end
            if (junk) in_valid[id] = 1'b0;
            nvec++;
            if (wcnt != LT[id] + 1) begin
                nerr++;
                $display("FAIL %s wait_len%0d: got %0d exp %0d", tn, k, wcnt, LT[id] + 1);
            end
        end

        nvec++;
        if ({res_valid[id], result[id]} !== {1'b1, exp_res}) begin
            nerr++;
            $display("FAIL %s result: valid %b value %h exp valid 1 value %h", tn, res_valid[id], result[id], exp_res);
        end
        for (int h = 0; h < hold; h++) begin
            start[id] = 1'($urandom_range(0, 1));
            in_valid[id] = 1'($urandom_range(0, 1));
            in_a[id] = 18'($urandom); in_b[id] = 18'($urandom);
            @(negedge clock);
            nvec++;
            if ({res_valid[id], in_ready[id], busy[id], result[id]} !== {3'b101, exp_res}) begin
                nerr++;
                $display("FAIL %s hold%0d: v/r/b %b%b%b res %h exp 101 res %h", tn, h,
                         res_valid[id], in_ready[id], busy[id], result[id], exp_res);
            end
        end
        start[id] = 1'b0; in_valid[id] = 1'b0; res_ack[id] = 1'b1;
        @(negedge clock);
        res_ack[id] = 1'b0;
        nvec++;
        if ({res_valid[id], busy[id], dbg[id]} !== 4'b0000) begin
            nerr++;
            $display("FAIL %s ack_idle: valid %b busy %b state %0d exp 0 0 0", tn, res_valid[id], busy[id], dbg[id]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            nvec++;
            if ({busy[i], in_ready[i], res_valid[i], dbg[i], mac_a[i], mac_b[i], mac_c[i], result[i]} !== '0) begin
                nerr++;
                $display("FAIL reset%0d: b%b r%b v%b s%0d a%h b%h c%h res%h exp all 0", i,
                         busy[i], in_ready[i], res_valid[i], dbg[i], mac_a[i], mac_b[i], mac_c[i], result[i]);
            end
        end
        reset = 1'b0;
        in_valid[0] = 1'b1; in_a[0] = 18'd7; in_b[0] = 18'd9;
        repeat (3) begin
            @(negedge clock);
            nvec++;
            if ({busy[0], in_ready[0]} !== 2'b00) begin
                nerr++;
                $display("FAIL idle_ignore: busy/in_ready got %b%b exp 00", busy[0], in_ready[0]);
            end
        end
        in_valid[0] = 1'b0;
    endtask

    task automatic test_basic();
        pa[0] = 18'sd10; pb[0] = 18'sd20;
        pa[1] = 18'sd1;  pb[1] = 18'sd2;
        pa[2] = 18'sd3;  pb[2] = 18'sd2;
        run_dot(0, 48'd30, 3, 0, 1'b0, 3, -1, "basic");
    endtask

    task automatic test_stalls();
        run_dot(0, 48'd30, 3, 5, 1'b1, 1, -1, "stalls");
    endtask

    task automatic test_long_latency();
        pa[0] = 18'sd4; pb[0] = 18'sd5;
        pa[1] = 18'sd6; pb[1] = 18'sd7;
        run_dot(1, 48'd0, 2, 0, 1'b0, 0, -1, "long_lat");
    endtask

    task automatic test_signed();
        logic [47:0] b;
        b = -48'sd5;
        pa[0] = -18'sd3; pb[0] = 18'sd4;
        run_dot(2, b, 1, 0, 1'b0, 1, -1, "signed");
    endtask

    task automatic test_reset_in_wait();
        for (int k = 0; k < 3; k++) begin
            pa[k] = 18'sd1; pb[k] = 18'sd1;
        end
        run_dot(0, 48'd100, 3, 0, 1'b0, 0, 1, "rst_wait");
        run_dot(0, 48'd0, 3, 0, 1'b0, 2, -1, "after_rst");
    endtask

    task automatic test_ack_backpressure();
        pa[0] = 18'sd10; pb[0] = 18'sd20;
        pa[1] = 18'sd1;  pb[1] = 18'sd2;
        pa[2] = 18'sd3;  pb[2] = 18'sd2;
        run_dot(0, 48'd30, 3, 0, 1'b0, 10, -1, "ack_bp");
    endtask

    task automatic test_random();
        int id;
        int gap;
        bit junk;
        logic [47:0] b;
        for (int r = 0; r < 30; r++) begin
            id = $urandom_range(0, NI - 1);
            for (int k = 0; k < 16; k++) begin
                pa[k] = 18'($urandom); pb[k] = 18'($urandom);
            end
            b    = {$urandom, $urandom};
            gap  = $urandom_range(0, 3);
            junk = (gap > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_dot(id, b, NT[id], gap, junk, $urandom_range(0, 4), -1, "random");
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; bias_v[i] = '0; in_valid[i] = 1'b0;
            in_a[i] = '0; in_b[i] = '0; res_ack[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_stalls();
        test_long_latency();
        test_signed();
        test_reset_in_wait();
        test_ack_backpressure();
        test_random();
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
